mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the ALU multiply operation (ALU control code 3'd2) in the EX stage.
- On a multiply in ID/EX it runs an iterative shift-add multiplier. It stalls the pipeline through the hazard unit until the product is ready, then presents the product to the EX result mux for one cycle.
- All other ALU operations pass it by with no stall.

Parameters:
- WIDTH, 32: operand and result width in bits.
- EARLY_OUT, 0: when 1, the iteration terminates once the remaining multiplier bits are all zero.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  ID/EX holds a valid instruction.
- ALUCtrl_i  input  3  ALU control code of that instruction; 3'd2 means multiply.
- flush_i  input  1  kills the EX-stage instruction, for example on a branch taken.
- data1_i  input  WIDTH  multiplicand (rs value).
- data2_i  input  WIDTH  multiplier (rt value).
- stall_o  output  1  hold PC, IF/ID and ID/EX; combinational.
- busy_o  output  1  registered; high while in RUN.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  output  WIDTH  registered product, low WIDTH bits.

Behaviour:
- States are IDLE, RUN and DONE. Internal registers: mcand, mplier, acc (all WIDTH bits) and cnt (clog2(WIDTH) bits).
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - acc, mcand, mplier, cnt, result_o and busy_o go to 0.
  - done_o and stall_o read 0 while reset is held.
  - Reset mid-RUN aborts the operation with no done_o pulse.
- Accept condition, in IDLE: start_i=1, ALUCtrl_i=3'd2 and flush_i=0 (cycle A). In cycle A:
  - stall_o=1, combinationally.
  - At the edge: mcand<=data1_i, mplier<=data2_i, acc<=0, cnt<=0, next state RUN.
  - Any other ALUCtrl_i, or flush_i=1, leaves the block in IDLE with stall_o=0.
- RUN, one iteration per cycle:
  - If mplier[0]=1, acc<=acc+mcand, taken mod 2^WIDTH.
  - mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - stall_o=1 and busy_o=1.
- RUN exit:
  - Exit when cnt==WIDTH-1. With EARLY_OUT=1, also exit when (mplier>>1)==0.
  - On exit, result_o<=the accumulated value including this iteration, and the next state is DONE.
- Latency: with EARLY_OUT=0, done_o is asserted in cycle A+WIDTH+1, and stall_o is high for WIDTH+1 cycles in total.
- DONE (one cycle):
  - stall_o=0, so the pipeline advances.
  - done_o=1, unless flush_i is high.
  - start_i is ignored; the stale ID/EX copy must not retrigger.
  - Next state is IDLE.
  - A multiply arriving in the following cycle is accepted normally, so back-to-back multiplies are separated by exactly one DONE cycle.
- Arithmetic: the product is unsigned shift-add truncated to WIDTH bits. It equals the low WIDTH bits of a signed product, so no sign handling is needed.
- flush_i:
  - In RUN: the next state is IDLE. stall_o drops in the same cycle (combinational term masked by flush_i), no done_o pulse, result_o unchanged.
  - In DONE: done_o is masked, the state still returns to IDLE, and result_o keeps its already-updated value.
- stall_o = (IDLE & accept condition) | (RUN & ~flush_i).
- result_o holds its value at all times except on the RUN→DONE edge.

Test Plan:
- Reset: assert rst_i=0 asynchronously mid-cycle → outputs 0 immediately, state IDLE. Then release, apply start_i=1, ALUCtrl_i=3'd0 → stall_o=0 and done_o never asserts.
- Basic multiply: 7*6, EARLY_OUT=0, WIDTH=32 → stall_o=1 for 33 cycles, done_o=1 in cycle A+33 with result_o=42, stall_o=0 that cycle. Hold start_i high through DONE → no re-accept.
- Truncation: 0xFFFFFFFF*0x00000002 → 0xFFFFFFFE. Then 0x80000000*0x80000000 → 0x00000000. Then 0x0001_0000*0x0001_0000 → 0.
- Flush: start 3*5, assert flush_i in RUN cycle 10 → stall_o=0 that cycle, IDLE next, no done_o, result_o still 42 from the earlier test. Also reset mid-RUN → same abort behaviour.
- Back-to-back: two multiplies 2*3 then 4*5 → done_o pulses with 6 then 20, exactly one non-stalled DONE cycle between the runs.
- EARLY_OUT=1: 5*3 → exactly 2 RUN cycles, done_o in cycle A+3, result_o=15. 9*0 → 1 RUN cycle, result_o=0.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// Handshake and data bundle between the EX stage and the multiply sequencer.
// The pipeline side drives the request and operands; the sequencer drives
// the stall, status and product back.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic             flush_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  // Pipeline / EX-stage side
  modport master (
    output start_i, ALUCtrl_i, flush_i, data1_i, data2_i,
    input  stall_o, busy_o, done_o, result_o
  );

  // Sequencer side
  modport slave (
    input  start_i, ALUCtrl_i, flush_i, data1_i, data2_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-add multiply sequencer for the EX stage.
// A multiply in ID/EX is accepted from IDLE, iterated one multiplier bit per
// cycle in RUN while the pipeline is stalled, and the product is presented
// for exactly one cycle in DONE. Non-multiply operations never stall.
module mul_seq_ctrl #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,   // active-low, asynchronous
  mul_seq_ctrl_if.slave  bus
);

  // Counter must hold WIDTH-1; a 1-bit counter covers the degenerate WIDTH=1.
  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [2:0]      ALU_MUL  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mcand_d;
  logic [WIDTH-1:0] mplier_d;
  logic [CW-1:0]    cnt_d;

  // Accept decode and one shift-add iteration of the datapath.
  always_comb begin
    accept   = (state_q == IDLE) && bus.start_i && (bus.ALUCtrl_i == ALU_MUL)
               && !bus.flush_i;
    // Addition wraps naturally: only the low WIDTH bits of the product matter,
    // which are identical for signed and unsigned operands.
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    cnt_d    = cnt_q + 1'b1;
    // Early exit fires when no set multiplier bits remain after this step.
    last_iter = (cnt_q == CNT_LAST) || ((EARLY_OUT != 0) && (mplier_d == '0));
  end

  // Sequencer FSM with its datapath registers and the registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            mcand_q  <= bus.data1_i;
            mplier_q <= bus.data2_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end

        RUN: begin
          if (bus.flush_i) begin
            // Killed instruction: abandon the product, keep the old result.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            if (last_iter) begin
              result_q <= acc_d;
              busy_q   <= 1'b0;
              state_q  <= DONE;
            end else begin
              busy_q   <= 1'b1;
            end
          end
        end

        DONE: begin
          // The ID/EX copy is stale here, so start_i is deliberately ignored.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall and done are combinational so the hazard unit reacts in the same
  // cycle; both are forced low while reset is held.
  always_comb begin
    bus.stall_o  = rst_i && (accept || ((state_q == RUN) && !bus.flush_i));
    bus.done_o   = rst_i && (state_q == DONE) && !bus.flush_i;
    bus.busy_o   = busy_q;
    bus.result_o = result_q;
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: one instance with full-length iteration
// and one with early termination, both driven from the same task set.
module tb_mul_seq_ctrl;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus and observed outputs (index 0: EARLY_OUT=0, 1: EARLY_OUT=1)
  logic        start [2];
  logic [2:0]  alu   [2];
  logic        flush [2];
  logic [31:0] d1    [2];
  logic [31:0] d2    [2];
  logic        stall_w  [2];
  logic        busy_w   [2];
  logic        done_w   [2];
  logic [31:0] result_w [2];

  mul_seq_ctrl_if #(.WIDTH(32)) i0 ();
  mul_seq_ctrl_if #(.WIDTH(32)) i1 ();

  assign i0.start_i   = start[0];
  assign i0.ALUCtrl_i = alu[0];
  assign i0.flush_i   = flush[0];
  assign i0.data1_i   = d1[0];
  assign i0.data2_i   = d2[0];
  assign stall_w[0]   = i0.stall_o;
  assign busy_w[0]    = i0.busy_o;
  assign done_w[0]    = i0.done_o;
  assign result_w[0]  = i0.result_o;

  assign i1.start_i   = start[1];
  assign i1.ALUCtrl_i = alu[1];
  assign i1.flush_i   = flush[1];
  assign i1.data1_i   = d1[1];
  assign i1.data2_i   = d2[1];
  assign stall_w[1]   = i1.stall_o;
  assign busy_w[1]    = i1.busy_o;
  assign done_w[1]    = i1.done_o;
  assign result_w[1]  = i1.result_o;

  mul_seq_ctrl #(.WIDTH(32), .EARLY_OUT(0)) u_full (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (i0.slave)
  );

  mul_seq_ctrl #(.WIDTH(32), .EARLY_OUT(1)) u_early (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (i1.slave)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt [2];
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (done_w[0]) begin
      done_cnt[0]++;
      if (sb0.size() == 0) check("sb0_unexpected_done", 1, 0);
      else check("result0", result_w[0], sb0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (done_w[1]) begin
      done_cnt[1]++;
      if (sb1.size() == 0) check("sb1_unexpected_done", 1, 0);
      else check("result1", result_w[1], sb1.pop_front());
    end
  end

  // Issue one multiply on instance k and track it to its done pulse.
  // hold keeps start_i high through RUN/DONE; chain leaves the next cycle
  // free for an immediate back-to-back multiply.
  task automatic mul(input int k, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input bit hold, input bit chain);
    int cyc;
    int stalls;
    int got;
    logic [31:0] prod;
    prod = a * b;
    @(posedge clk); #1;
    start[k] = 1'b1; alu[k] = 3'd2; d1[k] = a; d2[k] = b;
    if (k == 0) sb0.push_back(prod); else sb1.push_back(prod);
    cyc = 0; stalls = 0; got = -1;
    while (cyc <= 200) begin
      @(negedge clk);
      if (stall_w[k]) stalls++;
      if (done_w[k]) begin
        got = cyc;
        check("done_cycle_stall", stall_w[k], 0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (!hold) start[k] = 1'b0;
    end
    check("done_latency", got, exp_lat);
    check("stall_cycles", stalls, exp_lat);
    $display("mul[%0d] %h * %h exp=%h done_at=%0d stalls=%0d", k, a, b, prod, got, stalls);
    if (!chain) begin
      @(posedge clk); #1;
      start[k] = 1'b0;
      @(negedge clk);
      check("after_done_busy", busy_w[k], 0);
      check("after_done_stall", stall_w[k], 0);
      check("after_done_no_done", done_w[k], 0);
    end
  endtask

  // Flush instance 0 in RUN cycle 'at' of a 3*5 multiply.
  task automatic flush_run(input int at, input logic [31:0] prev);
    int dc;
    dc = done_cnt[0];
    @(posedge clk); #1;
    start[0] = 1'b1; alu[0] = 3'd2; d1[0] = 32'd3; d2[0] = 32'd5;
    for (int c = 1; c <= at; c++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    flush[0] = 1'b1;
    @(negedge clk);
    check("flush_run_busy_before", busy_w[0], 1);
    check("flush_run_stall", stall_w[0], 0);
    check("flush_run_done", done_w[0], 0);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    @(negedge clk);
    check("flush_run_idle_busy", busy_w[0], 0);
    check("flush_run_idle_stall", stall_w[0], 0);
    check("flush_run_result_kept", result_w[0], prev);
    repeat (40) @(negedge clk);
    check("flush_run_no_done", done_cnt[0], dc);
    $display("flush in RUN cycle %0d: result=%h", at, result_w[0]);
  endtask

  // Flush instance 0 in its DONE cycle: pulse masked, product still stored.
  task automatic flush_done(input logic [31:0] a, input logic [31:0] b);
    int dc;
    logic [31:0] prod;
    prod = a * b;
    dc = done_cnt[0];
    @(posedge clk); #1;
    start[0] = 1'b1; alu[0] = 3'd2; d1[0] = a; d2[0] = b;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    flush[0] = 1'b1;
    @(negedge clk);
    check("flush_done_masked", done_w[0], 0);
    check("flush_done_stall", stall_w[0], 0);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    @(negedge clk);
    check("flush_done_result", result_w[0], prod);
    check("flush_done_busy", busy_w[0], 0);
    check("flush_done_no_pulse", done_cnt[0], dc);
    $display("flush in DONE: result=%h", result_w[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    bit saw_stall;
    done_cnt[0] = 0; done_cnt[1] = 0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; alu[k] = 3'd0; flush[k] = 1'b0; d1[k] = '0; d2[k] = '0;
    end

    // Reset held with a multiply request present: everything reads 0.
    rst_n = 1'b0;
    start[0] = 1'b1; alu[0] = 3'd2; d1[0] = 32'd7; d2[0] = 32'd6;
    repeat (3) @(negedge clk);
    check("rst_stall", stall_w[0], 0);
    check("rst_busy", busy_w[0], 0);
    check("rst_done", done_w[0], 0);
    check("rst_result", result_w[0], 0);
    start[0] = 1'b0; alu[0] = 3'd0;
    #2 rst_n = 1'b1;

    // Non-multiply operation passes without stalling.
    dc = done_cnt[0];
    saw_stall = 1'b0;
    @(posedge clk); #1;
    start[0] = 1'b1; alu[0] = 3'd0; d1[0] = 32'd7; d2[0] = 32'd6;
    repeat (5) begin
      @(negedge clk);
      if (stall_w[0] || busy_w[0]) saw_stall = 1'b1;
    end
    start[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("nonmul_no_stall", saw_stall, 0);
    check("nonmul_no_done", done_cnt[0], dc);
    $display("non-multiply op: no stall, no done");

    // Basic multiply with start held through DONE.
    mul(0, 32'd7, 32'd6, 33, 1'b1, 1'b0);
    flush_run(10, 32'd42);

    // Truncation corners.
    mul(0, 32'hFFFF_FFFF, 32'h0000_0002, 33, 1'b0, 1'b0);
    mul(0, 32'h8000_0000, 32'h8000_0000, 33, 1'b0, 1'b0);
    mul(0, 32'h0001_0000, 32'h0001_0000, 33, 1'b0, 1'b0);
    mul(0, 32'h1234_5678, 32'h9ABC_DEF1, 33, 1'b0, 1'b0);

    // Back-to-back: second accepted in the cycle right after DONE.
    mul(0, 32'd2, 32'd3, 33, 1'b0, 1'b1);
    mul(0, 32'd4, 32'd5, 33, 1'b0, 1'b0);

    flush_done(32'd7, 32'd7);

    // Early-out instance: latency tracks the highest set multiplier bit.
    mul(1, 32'd5, 32'd3, 3, 1'b0, 1'b0);
    mul(1, 32'd9, 32'd0, 2, 1'b0, 1'b0);
    mul(1, 32'h1234_5678, 32'h0000_0100, 10, 1'b0, 1'b0);
    mul(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN aborts with no done pulse.
    dc = done_cnt[0];
    @(posedge clk); #1;
    start[0] = 1'b1; alu[0] = 3'd2; d1[0] = 32'd3; d2[0] = 32'd5;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrun_rst_stall", stall_w[0], 0);
    check("midrun_rst_busy", busy_w[0], 0);
    check("midrun_rst_done", done_w[0], 0);
    check("midrun_rst_result", result_w[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrun_rst_no_done", done_cnt[0], dc);
    check("midrun_rst_idle", busy_w[0], 0);
    $display("reset mid-RUN: aborted, result=%h", result_w[0]);

    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
